// File: rtl/time_set_ctrl.sv
// Time-setting controller placed in front of the sec/min/hour counter chain.
// Debounces MODE/INC, walks the field-select FSM, gates the 1 Hz tick in RUN
// and issues unit/ten increment pulses (with auto-repeat) while setting.

// Per-key front end: 2-FF synchroniser, stability counter, press-edge pulse.
module time_set_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic CP,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic press
);
  localparam int CW = $clog2(CYCLES);

  logic          s1, s2, lvl_q;
  logic [CW-1:0] cnt;

  // Accept the synced level only after it has disagreed with lvl for CYCLES samples.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
      if (s2 != lvl) begin
        if (cnt == CW'(CYCLES - 1)) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       run_en,
  output logic [2:0] inc_unit,
  output logic [2:0] inc_ten,
  output logic [2:0] field,
  output logic       digit_ten
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  typedef enum logic [2:0] {
    RUN, SET_HR_T, SET_HR_U, SET_MIN_T, SET_MIN_U, SET_SEC_T, SET_SEC_U
  } state_t;

  state_t        state, nxt;
  logic          mode_lvl, mode_press, inc_lvl, inc_press;
  logic          rep_act, rep_first;
  logic [RW-1:0] rc, rc_tgt;
  logic [2:0]    pls_unit, pls_ten;

  time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .CP(CP), .reset(reset), .raw(key_mode), .lvl(mode_lvl), .press(mode_press)
  );
  time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .CP(CP), .reset(reset), .raw(key_inc), .lvl(inc_lvl), .press(inc_press)
  );

  function automatic logic [2:0] fld_of(state_t s);
    case (s)
      SET_HR_T,  SET_HR_U:  fld_of = 3'b100;
      SET_MIN_T, SET_MIN_U: fld_of = 3'b010;
      SET_SEC_T, SET_SEC_U: fld_of = 3'b001;
      default:              fld_of = 3'b000;
    endcase
  endfunction

  function automatic logic ten_of(state_t s);
    ten_of = (s == SET_HR_T) || (s == SET_MIN_T) || (s == SET_SEC_T);
  endfunction

  // Next state on a MODE press, pulse routing for the field being edited.
  always_comb begin
    nxt = RUN;
    case (state)
      RUN:       nxt = SET_HR_T;
      SET_HR_T:  nxt = SET_HR_U;
      SET_HR_U:  nxt = SET_MIN_T;
      SET_MIN_T: nxt = SET_MIN_U;
      SET_MIN_U: nxt = SET_SEC_T;
      SET_SEC_T: nxt = SET_SEC_U;
      default:   nxt = RUN;
    endcase
    pls_ten  = digit_ten ? field : 3'b000;
    pls_unit = digit_ten ? 3'b000 : field;
    rc_tgt   = rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  end

  // The clock only advances in RUN; a SET state swallows the tick.
  assign run_en = tick & (state == RUN);

  // Field FSM, increment pulses and auto-repeat timing. MODE beats INC.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      field     <= 3'b000;
      digit_ten <= 1'b0;
      inc_unit  <= 3'b000;
      inc_ten   <= 3'b000;
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rc        <= '0;
    end else begin
      inc_unit <= 3'b000;
      inc_ten  <= 3'b000;
      if (mode_press) begin
        // A held INC keeps repeating in the new field, timed from the change.
        state     <= nxt;
        field     <= fld_of(nxt);
        digit_ten <= ten_of(nxt);
        rep_act   <= inc_lvl && (nxt != RUN);
        rep_first <= 1'b1;
        rc        <= (inc_lvl && (nxt != RUN)) ? RW'(1) : '0;
      end else if (state == RUN) begin
        rep_act <= 1'b0;
        rc      <= '0;
      end else if (inc_press) begin
        inc_unit  <= pls_unit;
        inc_ten   <= pls_ten;
        rep_act   <= 1'b1;
        rep_first <= 1'b1;
        rc        <= RW'(1);
      end else if (rep_act && inc_lvl) begin
        if (rc == rc_tgt) begin
          inc_unit  <= pls_unit;
          inc_ten   <= pls_ten;
          rep_first <= 1'b0;
          rc        <= '0;
        end else begin
          rc <= rc + RW'(1);
        end
      end else begin
        rep_act <= 1'b0;
        rc      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/repeat constants.
module tb_time_set_ctrl;
  logic       CP, reset, tick, key_mode, key_inc;
  logic       run_en, digit_ten;
  logic [2:0] inc_unit, inc_ten, field;
  int total = 0;
  int bad   = 0;

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)) dut (
    .CP(CP), .reset(reset), .tick(tick), .key_mode(key_mode), .key_inc(key_inc),
    .run_en(run_en), .inc_unit(inc_unit), .inc_ten(inc_ten), .field(field),
    .digit_ten(digit_ten)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic cyc();
    @(posedge CP);
    #1;
  endtask

  // Clean MODE press long enough to debounce, then a clean release.
  task automatic press_mode();
    key_mode = 1'b1;
    repeat (10) cyc();
    key_mode = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    #3;
    total++;
    if ({run_en, inc_unit, inc_ten, field, digit_ten} !== 11'b0) begin
      bad++;
      $display("FAIL reset_state got=%b exp=0", {run_en, inc_unit, inc_ten, field, digit_ten});
    end
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_run_tick();
    for (int k = 0; k < 30; k++) begin
      tick = (k % 10 == 0);
      #1;
      total++;
      if ({run_en, inc_unit, inc_ten, field, digit_ten} !== {tick, 10'b0}) begin
        bad++;
        $display("FAIL run_tick k=%0d got=%b exp=%b", k,
                 {run_en, inc_unit, inc_ten, field, digit_ten}, {tick, 10'b0});
      end
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic test_mode_press();
    logic [9:0] exp;
    key_mode = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      exp = (k >= 8) ? {3'b000, 3'b000, 3'b100, 1'b1} : 10'b0;
      total++;
      if ({inc_unit, inc_ten, field, digit_ten} !== exp) begin
        bad++;
        $display("FAIL mode_press k=%0d got=%b exp=%b", k, {inc_unit, inc_ten, field, digit_ten}, exp);
      end
    end
    key_mode = 1'b0;
    repeat (10) cyc();
    tick = 1'b1;
    #1;
    total++;
    if (run_en !== 1'b0) begin
      bad++;
      $display("FAIL frozen_tick got=%b exp=0", run_en);
    end
    cyc();
    tick = 1'b0;
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 30; k++) begin
      key_mode = (k < 20) && ((k / 2) % 2 == 0);
      cyc();
      total++;
      if ({field, digit_ten} !== 4'b1001) begin
        bad++;
        $display("FAIL bounce k=%0d got=%b exp=1001", k, {field, digit_ten});
      end
    end
    key_mode = 1'b0;
  endtask

  task automatic test_inc_repeat();
    logic [2:0] eu;
    repeat (3) press_mode();
    total++;
    if ({field, digit_ten} !== 4'b0100) begin
      bad++;
      $display("FAIL min_u_state got=%b exp=0100", {field, digit_ten});
    end
    key_inc = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      eu = (k == 8 || k == 23 || k == 31 || k == 39) ? 3'b010 : 3'b000;
      total++;
      if ({inc_unit, inc_ten} !== {eu, 3'b000}) begin
        bad++;
        $display("FAIL inc_repeat k=%0d got=%b exp=%b", k, {inc_unit, inc_ten}, {eu, 3'b000});
      end
      if (k == 40) key_inc = 1'b0;
    end
  endtask

  task automatic test_mode_cycle();
    logic [3:0] tab [7] = '{4'b1001, 4'b1000, 4'b0101, 4'b0100, 4'b0011, 4'b0010, 4'b0000};
    repeat (3) press_mode();
    total++;
    if ({field, digit_ten} !== 4'b0000) begin
      bad++;
      $display("FAIL back_to_run got=%b exp=0000", {field, digit_ten});
    end
    for (int i = 0; i < 7; i++) begin
      press_mode();
      total++;
      if ({field, digit_ten} !== tab[i]) begin
        bad++;
        $display("FAIL mode_cycle i=%0d got=%b exp=%b", i, {field, digit_ten}, tab[i]);
      end
    end
  endtask

  task automatic test_simul_and_reset();
    logic [5:0] ei;
    logic [3:0] es;
    repeat (5) press_mode();
    total++;
    if ({field, digit_ten} !== 4'b0011) begin
      bad++;
      $display("FAIL sec_t_state got=%b exp=0011", {field, digit_ten});
    end
    key_mode = 1'b1;
    key_inc  = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      cyc();
      if (k == 10) key_mode = 1'b0;
      ei = (k == 23) ? {3'b001, 3'b000} : 6'b0;
      es = (k >= 8) ? 4'b0010 : 4'b0011;
      total++;
      if ({inc_unit, inc_ten, field, digit_ten} !== {ei, es}) begin
        bad++;
        $display("FAIL simul k=%0d got=%b exp=%b", k, {inc_unit, inc_ten, field, digit_ten}, {ei, es});
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if ({run_en, inc_unit, inc_ten, field, digit_ten} !== 11'b0) begin
      bad++;
      $display("FAIL async_reset got=%b exp=0", {run_en, inc_unit, inc_ten, field, digit_ten});
    end
    key_inc = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_mode_press();
    test_bounce();
    test_inc_repeat();
    test_mode_cycle();
    test_simul_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
